// File: rtl/adder_pipelined_param_if.sv
// Operand/result bundle for the pipelined add/subtract unit.
// The master drives operands and stall; the slave returns registered results.
interface adder_pipelined_param_if #(
    parameter int WIDTH = 8
);
    logic             In_valid;
    logic             Op;
    logic             Carry_in;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Stall;
    logic             Out_valid;
    logic [WIDTH-1:0] Sum_reg;
    logic             Carry_reg;
    logic             Overflow_reg;

    modport master (
        output In_valid, Op, Carry_in, A, B, Stall,
        input  Out_valid, Sum_reg, Carry_reg, Overflow_reg
    );

    modport slave (
        input  In_valid, Op, Carry_in, A, B, Stall,
        output Out_valid, Sum_reg, Carry_reg, Overflow_reg
    );
endinterface

// File: rtl/adder_pipelined_param.sv
// Pipelined add/subtract unit: the carry chain is split into STAGES chunks,
// one chunk per register stage, with operands and partial sums skewed along.
module adder_pipelined_param #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic Clk,
    input logic Reset_n,
    adder_pipelined_param_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];
    logic             v_in  [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic             cy_d  [STAGES];
    logic             ovf_d;
    logic [CHUNK:0]   part;

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             cy_q  [STAGES];
    logic             vld_q [STAGES];
    logic             ovf_q;

    always_comb begin
        // Subtract is A + ~B + ~borrow; B is inverted once at entry.
        a_in[0] = bus.A;
        b_in[0] = bus.Op ? ~bus.B : bus.B;
        s_in[0] = '0;
        c_in[0] = bus.Carry_in ^ bus.Op;
        v_in[0] = bus.In_valid;
        for (int s = 1; s < STAGES; s++) begin
            a_in[s] = a_q[s-1];
            b_in[s] = b_q[s-1];
            s_in[s] = sum_q[s-1];
            c_in[s] = cy_q[s-1];
            v_in[s] = vld_q[s-1];
        end
        part = '0;
        for (int s = 0; s < STAGES; s++) begin
            part = {1'b0, a_in[s][s*CHUNK +: CHUNK]}
                 + {1'b0, b_in[s][s*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_in[s]};
            sum_d[s] = s_in[s];
            sum_d[s][s*CHUNK +: CHUNK] = part[CHUNK-1:0];
            cy_d[s] = part[CHUNK];
        end
        ovf_d = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1])
             && (sum_d[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
                cy_q[s]  <= 1'b0;
                vld_q[s] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (!bus.Stall) begin
            // Data only moves with a valid sample, so bubbles leave results held.
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s] <= v_in[s];
                if (v_in[s]) begin
                    a_q[s]   <= a_in[s];
                    b_q[s]   <= b_in[s];
                    sum_q[s] <= sum_d[s];
                    cy_q[s]  <= cy_d[s];
                end
            end
            if (v_in[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign bus.Out_valid    = vld_q[LAST];
    assign bus.Sum_reg      = sum_q[LAST];
    assign bus.Carry_reg    = cy_q[LAST];
    assign bus.Overflow_reg = ovf_q;
endmodule

// File: tb/tb_adder_pipelined_param.sv
// Scoreboard bench for adder_pipelined_param at WIDTH=8, STAGES=2.
// Directed vectors push hand-computed results; a negedge monitor checks them.
module tb_adder_pipelined_param;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        int               due;
    } exp_t;

    typedef enum int {K_NONE, K_RST, K_STALL, K_ADV} kind_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    adder_pipelined_param_if #(.WIDTH(WIDTH)) bus ();

    adder_pipelined_param #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    exp_t             q[$];
    kind_t            kind = K_NONE;
    int               adv_cnt = 0;
    int               checks = 0;
    int               fails = 0;
    logic [WIDTH-1:0] exp_s = '0;
    logic             exp_c = 1'b0;
    logic             exp_v = 1'b0;
    logic [WIDTH+1:0] snap = '0;
    logic             snap_ov = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Record what each edge did and what it accepted.
    always @(posedge Clk) begin
        if (!Reset_n) begin
            kind = K_RST;
            q.delete();
        end else if (bus.Stall) begin
            kind = K_STALL;
        end else begin
            kind = K_ADV;
            adv_cnt++;
            if (bus.In_valid)
                q.push_back('{exp_s, exp_c, exp_v, adv_cnt + STAGES - 1});
        end
    end

    always @(negedge Clk) begin
        case (kind)
            K_RST: begin
                check("reset_clear",
                      {21'd0, bus.Out_valid, bus.Sum_reg, bus.Carry_reg, bus.Overflow_reg},
                      32'd0);
            end
            K_STALL: begin
                check("stall_hold",
                      {21'd0, bus.Out_valid, bus.Sum_reg, bus.Carry_reg, bus.Overflow_reg},
                      {21'd0, snap_ov, snap});
            end
            K_ADV: begin
                if (bus.Out_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_out: got sum %h with no sample pending, expected none",
                                 bus.Sum_reg);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("result",
                              {22'd0, bus.Sum_reg, bus.Carry_reg, bus.Overflow_reg},
                              {22'd0, e.s, e.c, e.v});
                        check("latency", adv_cnt, e.due);
                    end
                end else begin
                    check("bubble_hold",
                          {22'd0, bus.Sum_reg, bus.Carry_reg, bus.Overflow_reg},
                          {22'd0, snap});
                end
            end
            default: ;
        endcase
        snap    = {bus.Sum_reg, bus.Carry_reg, bus.Overflow_reg};
        snap_ov = bus.Out_valid;
    end

    task automatic drive(input logic v, input logic st,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic op, input logic cin,
                         input logic [WIDTH-1:0] es, input logic ec, input logic ev);
        bus.In_valid = v;
        bus.Stall    = st;
        bus.A        = a;
        bus.B        = b;
        bus.Op       = op;
        bus.Carry_in = cin;
        exp_s        = es;
        exp_c        = ec;
        exp_v        = ev;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        bus.In_valid = 1'b0;
        bus.Stall    = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.Op       = 1'b0;
        bus.Carry_in = 1'b0;
        Reset_n      = 1'b0;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        idle(1);

        // Single add with wrap
        drive(1, 0, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
        idle(3);

        // Back-to-back add/sub with overflow cases
        drive(1, 0, 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
        drive(1, 0, 8'h05, 8'h07, 1, 0, 8'hFE, 0, 0);
        drive(1, 0, 8'h80, 8'h01, 1, 0, 8'h7F, 1, 1);
        idle(3);

        // Carry and borrow across the chunk boundary
        drive(1, 0, 8'h0F, 8'h01, 0, 1, 8'h11, 0, 0);
        drive(1, 0, 8'h10, 8'h00, 1, 1, 8'h0F, 1, 0);
        idle(3);

        // Stall two cycles with samples in flight; the stalled sample is re-presented
        drive(1, 0, 8'h01, 8'h02, 0, 0, 8'h03, 0, 0);
        drive(1, 0, 8'h40, 8'h40, 0, 0, 8'h80, 0, 1);
        drive(1, 1, 8'hFF, 8'hFF, 0, 1, 8'hFF, 1, 0);
        drive(1, 1, 8'hFF, 8'hFF, 0, 1, 8'hFF, 1, 0);
        drive(1, 0, 8'hFF, 8'hFF, 0, 1, 8'hFF, 1, 0);
        idle(4);

        // Reset mid-stream discards in-flight samples
        drive(1, 0, 8'h11, 8'h11, 0, 0, 8'h22, 0, 0);
        Reset_n = 1'b0;
        drive(1, 0, 8'h33, 8'h33, 0, 0, 8'h66, 0, 0);
        Reset_n = 1'b1;
        drive(1, 0, 8'h20, 8'h10, 1, 0, 8'h10, 1, 0);
        idle(3);

        // Reset wins over stall
        drive(1, 0, 8'h80, 8'h80, 0, 0, 8'h00, 1, 1);
        Reset_n = 1'b0;
        drive(0, 1, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0);
        Reset_n = 1'b1;
        drive(1, 0, 8'h00, 8'h01, 1, 0, 8'hFF, 0, 0);
        drive(1, 0, 8'h80, 8'h80, 0, 0, 8'h00, 1, 1);
        idle(4);

        check("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/adder_pipelined_param.md
Name: adder_pipelined_param

Overview:
- Parametrised, pipelined, registered add/subtract unit; next generation of the team's 2-bit registered synchronous adder.
- Operand width is generalised to WIDTH. The carry chain is split across STAGES register stages to meet timing at wide widths.
- Adds a valid qualifier, stall/hold, subtract mode, carry-in and signed overflow.
- Sits between registered datapath blocks, which feed it and consume its registered outputs.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 2 and a multiple of STAGES.
- STAGES, 2, number of pipeline stages (1..WIDTH); each stage resolves CHUNK = WIDTH/STAGES bits of the carry chain; also the latency in cycles.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset_n  input  1  synchronous active-low reset, sampled on posedge Clk.
- In_valid  input  1  A, B, Op, Carry_in carry a sample this cycle.
- Op  input  1  0 = add, 1 = subtract.
- Carry_in  input  1  add: carry in; subtract: borrow in (1 = subtract one more).
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- Stall  input  1  1 = freeze entire pipeline this cycle.
- Out_valid  output  1  Sum_reg/Carry_reg/Overflow_reg hold a new result.
- Sum_reg  output  WIDTH  registered result.
- Carry_reg  output  1  registered carry out of MSB; on subtract, 1 = no borrow.
- Overflow_reg  output  1  registered two's-complement signed overflow.

Behaviour:
- Reset: synchronous, active-low. When Reset_n=0 at a posedge, all stage valid bits, Out_valid, Sum_reg, Carry_reg, Overflow_reg and all internal pipeline registers clear to 0. Reset has priority over Stall and In_valid.
- Arithmetic per sample:
  - Op=0: {Carry, Sum} = A + B + Carry_in.
  - Op=1: {Carry, Sum} = A + ~B + ~Carry_in, i.e. A - B - Carry_in in two's complement.
  - Overflow = (A[MSB] == B'[MSB]) && (Sum[MSB] != A[MSB]), where B' is B or ~B per Op.
- Pipeline structure:
  - Stage s (1..STAGES) adds chunk s-1 (bits s*CHUNK-1 : (s-1)*CHUNK) using the carry registered out of stage s-1. Stage 1 uses Op-adjusted Carry_in.
  - Lower result chunks and higher operand chunks are carried along (skewed) in stage registers, so each sample stays aligned as it moves through the pipeline.
  - Each stage holds one valid bit.
- Latency: exactly STAGES accepting edges. A sample presented with In_valid=1 and Stall=0 before edge n appears with Out_valid=1 after edge n+STAGES-1, provided no stall intervenes; each stalled edge adds one cycle.
- STAGES=1: single stage; result registered on the first edge; behaves as the legacy registered adder plus the new ports.
- Throughput: one sample per cycle when Stall=0; back-to-back samples are fully supported.
- Bubbles: In_valid=0 with Stall=0 inserts a bubble. When a bubble reaches the output, Out_valid=0 and Sum_reg/Carry_reg/Overflow_reg hold their previous values.
- Stall=1 (Reset_n=1):
  - Every register, including outputs and Out_valid, holds.
  - In_valid and operands are ignored that cycle; upstream must re-present the sample.
  - Stall on consecutive cycles holds indefinitely.
- Simultaneous In_valid=1 and Stall=1: the sample is not accepted.
- Reset mid-stream: all in-flight samples are discarded. The first sample accepted after Reset_n returns high emerges after STAGES edges, with no residue from earlier samples.
- Out_valid is asserted for exactly one cycle per accepted sample, unless that cycle is stalled, in which case it persists through the stall.
- Wrap-around: sum is modulo 2^WIDTH; carry and overflow report the wrap. No saturation.

Test Plan:
- WIDTH=8, STAGES=2; A=8'hFF, B=8'h01, Op=0, Carry_in=0, one valid cycle -> 2 edges later Out_valid=1, Sum_reg=8'h00, Carry_reg=1, Overflow_reg=0; next cycle Out_valid=0 and outputs hold.
- WIDTH=8, STAGES=2; back-to-back A=8'h7F+B=8'h01 (Op=0), then A=8'h05-B=8'h07 (Op=1), then A=8'h80-B=8'h01 (Op=1), all Carry_in=0 -> consecutive results:
  - 8'h80, C=0, V=1
  - 8'hFE, C=0, V=0
  - 8'h7F, C=1, V=1
  - Out_valid high 3 consecutive cycles.
- Carry across stage boundary: A=8'h0F, B=8'h01, Op=0, Carry_in=1 -> Sum_reg=8'h11, C=0, V=0. Also Op=1, Carry_in=1, A=8'h10, B=8'h00 -> Sum_reg=8'h0F, C=1.
- Stall: stream 3 samples; assert Stall for 2 cycles while samples are in flight -> outputs and Out_valid frozen during the stall; all 3 results emerge in order, each exactly once, with latency extended by 2.
- Reset mid-operation: 2 samples in flight, Reset_n=0 for one edge -> Out_valid=0 and all outputs 0 next cycle; the in-flight results never appear; a new sample after reset gives the correct result at latency 2. Reset_n=0 with Stall=1 still clears.
- Parameter sweep: WIDTH=32 with STAGES in {1, 4, 32}; random operands, Op, Carry_in, In_valid and Stall vs. a reference model -> bit-exact Sum/Carry/Overflow, latency = STAGES plus stall count.
